// File: rtl/apb_rr_scheduler_if.sv
// APB master-side bus bundle for the round-robin scheduler.
// The scheduler drives the master modport and the slave fabric uses the slave modport.
interface apb_rr_scheduler_if;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Pready;
  logic        Pslverr;
  logic [31:0] Prdata;

  modport master (
    output Pselx, Penable, Pwrite, Paddr, Pwdata,
    input  Pready, Pslverr, Prdata
  );

  modport slave (
    input  Pselx, Penable, Pwrite, Paddr, Pwdata,
    output Pready, Pslverr, Prdata
  );
endinterface

// File: rtl/apb_rr_scheduler.sv
// Round-robin arbiter sharing one APB master among NREQ requesters.
// Each granted request runs SETUP/ACCESS with wait states, decode check and timeout.
module apb_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 Hclk,
  input  logic                 Hresetn,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_write,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*32-1:0]   req_wdata,
  output logic [NREQ-1:0]      done,
  output logic                 rsp_err,
  output logic [31:0]          rsp_rdata,
  apb_rr_scheduler_if.master   apb
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [31:0] addr_arr  [NREQ];
  logic [31:0] wdata_arr [NREQ];
  logic [2:0]  sel_arr   [NREQ];

  function automatic logic [2:0] decode_sel(input logic [31:0] a);
    case (a[31:26])
      6'h20:   decode_sel = 3'b001;
      6'h21:   decode_sel = 3'b010;
      6'h22:   decode_sel = 3'b100;
      default: decode_sel = 3'b000;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
      assign addr_arr[gi]  = req_addr[32*gi +: 32];
      assign wdata_arr[gi] = req_wdata[32*gi +: 32];
      assign sel_arr[gi]   = decode_sel(req_addr[32*gi +: 32]);
    end
  endgenerate

  // Rotate req so bit 0 is the requester at ptr, then pick the first set bit.
  logic [2*NREQ-1:0] req_dbl;
  logic [IDX_W:0]    off;
  logic [IDX_W:0]    sum;
  logic              found;
  logic [IDX_W-1:0]  winner;
  logic [IDX_W-1:0]  ptr_next;

  always_comb begin
    req_dbl = {req, req} >> ptr_reg;
    found   = 1'b0;
    off     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_dbl[k]) begin
        found = 1'b1;
        off   = (IDX_W+1)'(k);
      end
    end
    sum = {1'b0, ptr_reg} + off;
    if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
    winner   = sum[IDX_W-1:0];
    ptr_next = (winner == IDX_W'(NREQ-1)) ? '0 : winner + 1'b1;
  end

  logic [NREQ-1:0] one_lsb;
  assign one_lsb = {{(NREQ-1){1'b0}}, 1'b1};

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      idx_reg     <= '0;
      cnt_reg     <= '0;
      apb.Pselx   <= 3'b000;
      apb.Penable <= 1'b0;
      apb.Pwrite  <= 1'b0;
      apb.Paddr   <= 32'h0;
      apb.Pwdata  <= 32'h0;
      done        <= '0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            idx_reg <= winner;
            ptr_reg <= ptr_next;
            if (sel_arr[winner] != 3'b000) begin
              state_reg  <= SETUP;
              cnt_reg    <= '0;
              apb.Pselx  <= sel_arr[winner];
              apb.Paddr  <= addr_arr[winner];
              apb.Pwrite <= req_write[winner];
              apb.Pwdata <= req_write[winner] ? wdata_arr[winner] : 32'h0;
            end else begin
              // Unmapped address: answer directly without touching the bus.
              state_reg <= RESP;
              done      <= one_lsb << winner;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end
        end
        SETUP: begin
          apb.Penable <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (apb.Pready || cnt_reg == CNT_W'(TIMEOUT-1)) begin
            state_reg   <= RESP;
            apb.Pselx   <= 3'b000;
            apb.Penable <= 1'b0;
            apb.Pwrite  <= 1'b0;
            apb.Paddr   <= 32'h0;
            apb.Pwdata  <= 32'h0;
            done        <= one_lsb << idx_reg;
            // Pready takes priority over a coincident timeout.
            if (apb.Pready) begin
              rsp_err   <= apb.Pslverr;
              rsp_rdata <= (!apb.Pwrite && !apb.Pslverr) ? apb.Prdata : 32'h0;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          done      <= '0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_rr_scheduler.sv
// Directed bench for apb_rr_scheduler: one task per scenario with inline checks.
// A small APB slave process answers with a programmable number of wait states.
module tb_apb_rr_scheduler;
  localparam int NREQ = 4;

  logic              Hclk = 1'b0;
  logic              Hresetn;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ-1:0]   req_write = '0;
  logic [NREQ*32-1:0] req_addr = '0;
  logic [NREQ*32-1:0] req_wdata = '0;
  logic [NREQ-1:0]   done;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;

  apb_rr_scheduler_if apb_bus ();

  apb_rr_scheduler #(.NREQ(NREQ), .TIMEOUT(16)) dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .done      (done),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .apb       (apb_bus)
  );

  always #5 Hclk = ~Hclk;

  int tests_run = 0;
  int tests_failed = 0;

  // Slave model settings.
  int          wait_n = 0;
  bit          stuck = 0;
  bit          slv_err = 0;
  logic [31:0] slv_rdata = 32'h0;
  int          acc = 0;

  always @(negedge Hclk) begin
    if (apb_bus.Penable) begin
      apb_bus.Pready = !stuck && (acc >= wait_n);
      acc++;
    end else begin
      acc = 0;
      apb_bus.Pready = 1'b0;
    end
    apb_bus.Pslverr = slv_err && apb_bus.Pready;
    apb_bus.Prdata  = slv_rdata;
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic wr, input logic [31:0] w);
    req_addr[32*i +: 32]  = a;
    req_wdata[32*i +: 32] = w;
    req_write[i]          = wr;
  endtask

  task automatic do_reset();
    Hresetn = 1'b0;
    repeat (2) @(negedge Hclk);
    Hresetn = 1'b1;
  endtask

  // Steps negedges until done is seen; cycles=-1 means no done within the bound.
  task automatic wait_done(output int cycles, output logic [3:0] d, output logic e,
                           output logic [31:0] rd, output int pen, output int sel,
                           output bit stable, output logic [31:0] paddr_seen,
                           output logic [31:0] pwdata_seen);
    bit have = 0;
    cycles = -1; d = '0; e = 1'b0; rd = '0; pen = 0; sel = 0; stable = 1;
    paddr_seen = '0; pwdata_seen = '0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge Hclk);
      if (apb_bus.Penable) begin
        pen++;
        if (!have) begin
          paddr_seen = apb_bus.Paddr; pwdata_seen = apb_bus.Pwdata; have = 1;
        end else if (apb_bus.Paddr !== paddr_seen || apb_bus.Pwdata !== pwdata_seen) begin
          stable = 0;
        end
      end
      if (apb_bus.Pselx !== 3'b000) sel++;
      if (done !== '0) begin
        cycles = c; d = done; e = rsp_err; rd = rsp_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    Hresetn = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h8000_0000 + 32'(i*4), 1'b1, 32'h55);
    req = 4'b1111;
    repeat (3) @(negedge Hclk);
    tests_run++; if (apb_bus.Pselx !== 3'b000) begin tests_failed++; $display("FAIL reset_pselx got %b want 000", apb_bus.Pselx); end
    tests_run++; if (apb_bus.Penable !== 1'b0) begin tests_failed++; $display("FAIL reset_penable got %b want 0", apb_bus.Penable); end
    tests_run++; if ({apb_bus.Pwrite, apb_bus.Paddr, apb_bus.Pwdata} !== 65'h0) begin tests_failed++; $display("FAIL reset_bus got %b/%h/%h want 0", apb_bus.Pwrite, apb_bus.Paddr, apb_bus.Pwdata); end
    tests_run++; if ({done, rsp_err, rsp_rdata} !== 37'h0) begin tests_failed++; $display("FAIL reset_rsp got %b/%b/%h want 0", done, rsp_err, rsp_rdata); end
    req = '0;
    @(negedge Hclk);
    Hresetn = 1'b1;
    @(negedge Hclk);
  endtask

  task automatic test_single_read();
    int cyc, pen, sel; logic [3:0] d; logic e; logic [31:0] rd, pa, pw; bit st;
    set_req(0, 32'h8000_00A2, 1'b0, 32'hFFFF_FFFF);
    wait_n = 0; slv_rdata = 32'h5A;
    req = 4'b0001;
    wait_done(cyc, d, e, rd, pen, sel, st, pa, pw);
    req = '0;
    tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL read_latency got %0d want 3", cyc); end
    tests_run++; if (d !== 4'b0001) begin tests_failed++; $display("FAIL read_done got %b want 0001", d); end
    tests_run++; if (rd !== 32'h5A || e !== 1'b0) begin tests_failed++; $display("FAIL read_rsp got %h/%b want 0000005a/0", rd, e); end
    tests_run++; if (sel !== 2 || pen !== 1) begin tests_failed++; $display("FAIL read_phases got sel=%0d pen=%0d want 2/1", sel, pen); end
    tests_run++; if (pa !== 32'h8000_00A2 || pw !== 32'h0) begin tests_failed++; $display("FAIL read_bus got %h/%h want 800000a2/0", pa, pw); end
    @(negedge Hclk);
    tests_run++; if (done !== '0) begin tests_failed++; $display("FAIL read_done_pulse got %b want 0000", done); end
  endtask

  task automatic test_single_write();
    int cyc, pen, sel; logic [3:0] d; logic e; logic [31:0] rd, pa, pw; bit st;
    set_req(2, 32'h8800_0010, 1'b1, 32'hA3);
    wait_n = 0; slv_rdata = 32'hDEAD_BEEF;
    req = 4'b0100;
    @(negedge Hclk);
    tests_run++; if (apb_bus.Pselx !== 3'b100 || apb_bus.Penable !== 1'b0) begin tests_failed++; $display("FAIL write_setup got sel=%b en=%b want 100/0", apb_bus.Pselx, apb_bus.Penable); end
    tests_run++; if (apb_bus.Pwrite !== 1'b1 || apb_bus.Pwdata !== 32'hA3 || apb_bus.Paddr !== 32'h8800_0010) begin tests_failed++; $display("FAIL write_setup_bus got %b/%h/%h want 1/000000a3/88000010", apb_bus.Pwrite, apb_bus.Pwdata, apb_bus.Paddr); end
    wait_done(cyc, d, e, rd, pen, sel, st, pa, pw);
    req = '0;
    tests_run++; if (cyc !== 2 || pen !== 1) begin tests_failed++; $display("FAIL write_access got cyc=%0d pen=%0d want 2/1", cyc, pen); end
    tests_run++; if (d !== 4'b0100 || e !== 1'b0 || rd !== 32'h0) begin tests_failed++; $display("FAIL write_rsp got %b/%b/%h want 0100/0/0", d, e, rd); end
    @(negedge Hclk);
  endtask

  task automatic test_wait_states();
    int cyc, pen, sel; logic [3:0] d; logic e; logic [31:0] rd, pa, pw; bit st;
    set_req(1, 32'h8400_0004, 1'b0, 32'h0);
    wait_n = 3; slv_rdata = 32'h0000_1234;
    req = 4'b0010;
    wait_done(cyc, d, e, rd, pen, sel, st, pa, pw);
    req = '0; wait_n = 0;
    tests_run++; if (cyc !== 6) begin tests_failed++; $display("FAIL wait_latency got %0d want 6", cyc); end
    tests_run++; if (pen !== 4 || st !== 1'b1) begin tests_failed++; $display("FAIL wait_access got pen=%0d stable=%0d want 4/1", pen, st); end
    tests_run++; if (d !== 4'b0010 || rd !== 32'h1234 || e !== 1'b0) begin tests_failed++; $display("FAIL wait_rsp got %b/%h/%b want 0010/00001234/0", d, rd, e); end
    @(negedge Hclk);
  endtask

  task automatic test_decode_error();
    int cyc, pen, sel; logic [3:0] d; logic e; logic [31:0] rd, pa, pw; bit st;
    set_req(3, 32'h9000_0000, 1'b0, 32'h0);
    slv_rdata = 32'h1111_1111;
    req = 4'b1000;
    wait_done(cyc, d, e, rd, pen, sel, st, pa, pw);
    req = '0;
    tests_run++; if (cyc !== 1) begin tests_failed++; $display("FAIL decerr_latency got %0d want 1", cyc); end
    tests_run++; if (sel !== 0 || pen !== 0) begin tests_failed++; $display("FAIL decerr_bus got sel=%0d pen=%0d want 0/0", sel, pen); end
    tests_run++; if (d !== 4'b1000 || e !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL decerr_rsp got %b/%b/%h want 1000/1/0", d, e, rd); end
    @(negedge Hclk);
  endtask

  task automatic test_timeout();
    int cyc, pen, sel; logic [3:0] d; logic e; logic [31:0] rd, pa, pw; bit st;
    set_req(0, 32'h8000_1000, 1'b0, 32'h0);
    stuck = 1; slv_rdata = 32'h2222_2222;
    req = 4'b0001;
    wait_done(cyc, d, e, rd, pen, sel, st, pa, pw);
    req = '0; stuck = 0;
    tests_run++; if (cyc !== 18 || pen !== 16) begin tests_failed++; $display("FAIL timeout_len got cyc=%0d pen=%0d want 18/16", cyc, pen); end
    tests_run++; if (d !== 4'b0001 || e !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL timeout_rsp got %b/%b/%h want 0001/1/0", d, e, rd); end
    @(negedge Hclk);
  endtask

  task automatic test_slverr();
    int cyc, pen, sel; logic [3:0] d; logic e; logic [31:0] rd, pa, pw; bit st;
    set_req(1, 32'h8400_0100, 1'b0, 32'h0);
    slv_err = 1; slv_rdata = 32'h77;
    req = 4'b0010;
    wait_done(cyc, d, e, rd, pen, sel, st, pa, pw);
    req = '0; slv_err = 0;
    tests_run++; if (cyc !== 3) begin tests_failed++; $display("FAIL slverr_latency got %0d want 3", cyc); end
    tests_run++; if (d !== 4'b0010 || e !== 1'b1 || rd !== 32'h0) begin tests_failed++; $display("FAIL slverr_rsp got %b/%b/%h want 0010/1/0", d, e, rd); end
    @(negedge Hclk);
  endtask

  task automatic test_round_robin();
    int cyc, pen, sel; logic [3:0] d; logic e; logic [31:0] rd, pa, pw; bit st;
    logic [3:0] exp_order [5];
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h8000_0200 + 32'(i*4), 1'b0, 32'h0);
    wait_n = 0; slv_rdata = 32'h0000_00C3;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_done(cyc, d, e, rd, pen, sel, st, pa, pw);
      tests_run++; if (d !== exp_order[t]) begin tests_failed++; $display("FAIL rr_order[%0d] got %b want %b", t, d, exp_order[t]); end
      tests_run++; if (cyc !== ((t == 0) ? 3 : 4) || sel !== 2) begin tests_failed++; $display("FAIL rr_gap[%0d] got cyc=%0d sel=%0d want %0d/2", t, cyc, sel, (t == 0) ? 3 : 4); end
    end
    req = '0;
    @(negedge Hclk);
  endtask

  task automatic test_reset_mid_access();
    int cyc, pen, sel; logic [3:0] d; logic e; logic [31:0] rd, pa, pw; bit st;
    set_req(2, 32'h8000_0020, 1'b0, 32'h0);
    stuck = 1;
    req = 4'b0100;
    repeat (2) @(negedge Hclk);
    tests_run++; if (apb_bus.Penable !== 1'b1) begin tests_failed++; $display("FAIL midrst_in_access got %b want 1", apb_bus.Penable); end
    #2 Hresetn = 1'b0;
    #1;
    tests_run++; if (apb_bus.Pselx !== 3'b000 || apb_bus.Penable !== 1'b0 || done !== '0) begin tests_failed++; $display("FAIL midrst_async got %b/%b/%b want 000/0/0000", apb_bus.Pselx, apb_bus.Penable, done); end
    req = '0; stuck = 0;
    repeat (2) @(negedge Hclk);
    set_req(0, 32'h8000_0030, 1'b0, 32'h0);
    set_req(3, 32'h8800_0030, 1'b0, 32'h0);
    Hresetn = 1'b1;
    req = 4'b1001;
    wait_done(cyc, d, e, rd, pen, sel, st, pa, pw);
    req = '0;
    tests_run++; if (d !== 4'b0001 || cyc !== 3) begin tests_failed++; $display("FAIL midrst_first_grant got %b/%0d want 0001/3", d, cyc); end
    @(negedge Hclk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_wait_states();
    test_decode_error();
    test_timeout();
    test_slverr();
    test_round_robin();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
